// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window generator, conv_top and benches.
package conv_pkg;

    localparam int IF_CHANNEL  = 3;
    localparam int IF_BITWIDTH = 16;
    localparam int K_WIDTH     = 3;
    localparam int K_HEIGHT    = 3;
    localparam int IF_PORT     = K_WIDTH * K_HEIGHT * IF_CHANNEL;
    localparam int K_R         = (K_WIDTH - 1) / 2;
    localparam int PIX_W       = IF_CHANNEL * IF_BITWIDTH;
    localparam int WIN_W       = IF_PORT * IF_BITWIDTH;

    typedef logic [IF_CHANNEL-1:0][IF_BITWIDTH-1:0] pixel_t;
    typedef logic [IF_PORT-1:0][IF_BITWIDTH-1:0]    window_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } win_state_e;

    function automatic int port_idx(input int c, input int ky, input int kx);
        return c * K_HEIGHT * K_WIDTH + ky * K_WIDTH + kx;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One buffered image line: 1R1W RAM with asynchronous read, so a same-address write
// in the same cycle returns the old contents (read-before-write).
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata_o = mem[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to K_HEIGHT x K_WIDTH x IF_CHANNEL windows, stride 1, "same" padding.
// Build option WIN_EDGE_REPLICATE_EN: out-of-image taps clamp to the nearest in-image pixel instead of 0.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IF_WIDTH  = 128,
    parameter int IF_HEIGHT = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [PIX_W-1:0]   s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [WIN_W-1:0]   w_data,
    output logic [IF_PORT-1:0] w_valid,
    input  logic               w_ready
);

    localparam int AW  = (IF_WIDTH > 1) ? $clog2(IF_WIDTH) : 1;
    localparam int VXW = $clog2(IF_WIDTH + K_R + 1);
    localparam int VYW = $clog2(IF_HEIGHT + K_R + 1);

    localparam logic [VXW-1:0] X_IMG  = VXW'(IF_WIDTH);
    localparam logic [VXW-1:0] X_LAST = VXW'(IF_WIDTH + K_R - 1);
    localparam logic [VXW-1:0] X_R    = VXW'(K_R);
    localparam logic [VYW-1:0] Y_IMG  = VYW'(IF_HEIGHT);
    localparam logic [VYW-1:0] Y_LAST = VYW'(IF_HEIGHT + K_R - 1);
    localparam logic [VYW-1:0] Y_R    = VYW'(K_R);

    win_state_e     state_q;
    logic [VXW-1:0] vx_q;
    logic [VYW-1:0] vy_q;
    logic           busy_q, done_q, w_valid_q;
    window_t        w_data_q, w_data_d;
    pixel_t         win_q [K_HEIGHT][K_WIDTH];
    pixel_t         win_d [K_HEIGHT][K_WIDTH];
    pixel_t         col   [K_HEIGHT];
    pixel_t         lb_rd [K_HEIGHT-1];
    pixel_t         lb_wd [K_HEIGHT-1];
    pixel_t         pix_in;
    logic           real_pos, out_free, adv, load, last_pos, lb_we;

    always_comb begin
        real_pos = (vx_q < X_IMG) && (vy_q < Y_IMG);
        out_free = !w_valid_q || w_ready;
        adv      = (state_q == ST_RUN) && out_free && (!real_pos || s_valid);
        load     = adv && (vx_q >= X_R) && (vy_q >= Y_R);
        last_pos = (vx_q == X_LAST) && (vy_q == Y_LAST);
        lb_we    = adv && (vx_q < X_IMG);
        pix_in   = real_pos ? pixel_t'(s_data) : '0;
    end

    assign s_ready = (state_q == ST_RUN) && real_pos && out_free;

    // lb_rd[0] holds the row just above the current one, lb_rd[1] the row above that.
    for (genvar i = 0; i < K_HEIGHT - 1; i++) begin : g_lb
        if (i == 0) begin : g_first
            assign lb_wd[i] = pix_in;
        end else begin : g_chain
            assign lb_wd[i] = lb_rd[i-1];
        end
        conv_line_buffer #(
            .DEPTH (IF_WIDTH),
            .AW    (AW)
        ) u_lb (
            .clk_i   (clk),
            .we_i    (lb_we),
            .addr_i  (vx_q[AW-1:0]),
            .wdata_i (lb_wd[i]),
            .rdata_o (lb_rd[i])
        );
    end

    always_comb begin
        for (int ky = 0; ky < K_HEIGHT; ky++) begin
            col[ky] = '0;
        end
        if (vx_q < X_IMG) begin
            for (int ky = 0; ky < K_HEIGHT - 1; ky++) begin
                col[ky] = lb_rd[K_HEIGHT-2-ky];
            end
            col[K_HEIGHT-1] = pix_in;
        end
        for (int ky = 0; ky < K_HEIGHT; ky++) begin
            for (int kx = 0; kx < K_WIDTH - 1; kx++) begin
                win_d[ky][kx] = win_q[ky][kx+1];
            end
            win_d[ky][K_WIDTH-1] = col[ky];
        end
    end

    // Tap (ky,kx) of the window centred on (cy,cx) maps to image pixel (cy+ky-R, cx+kx-R).
    always_comb begin : tap_sel
        int cy, cx, r, cc;
`ifdef WIN_EDGE_REPLICATE_EN
        int sy, sx;
`endif
        w_data_d = '0;
        cy = int'(vy_q) - K_R;
        cx = int'(vx_q) - K_R;
        for (int ky = 0; ky < K_HEIGHT; ky++) begin
            for (int kx = 0; kx < K_WIDTH; kx++) begin
                r  = cy + ky - K_R;
                cc = cx + kx - K_R;
`ifdef WIN_EDGE_REPLICATE_EN
                sy = (r < 0) ? (K_R - cy) : (r >= IF_HEIGHT) ? (IF_HEIGHT - 1 - cy + K_R) : ky;
                sx = (cc < 0) ? (K_R - cx) : (cc >= IF_WIDTH) ? (IF_WIDTH - 1 - cx + K_R) : kx;
                for (int ky2 = 0; ky2 < K_HEIGHT; ky2++) begin
                    for (int kx2 = 0; kx2 < K_WIDTH; kx2++) begin
                        if (ky2 == sy && kx2 == sx) begin
                            for (int c = 0; c < IF_CHANNEL; c++) begin
                                w_data_d[port_idx(c, ky, kx)] = win_d[ky2][kx2][c];
                            end
                        end
                    end
                end
`else
                if (r >= 0 && r < IF_HEIGHT && cc >= 0 && cc < IF_WIDTH) begin
                    for (int c = 0; c < IF_CHANNEL; c++) begin
                        w_data_d[port_idx(c, ky, kx)] = win_d[ky][kx][c];
                    end
                end
`endif
            end
        end
    end

    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_RUN   | walking the virtual raster, one position per advance
    // ST_DRAIN | all positions advanced, waiting for the last window to be taken
    // ST_DONE  | done pulse, back to idle next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vx_q      <= '0;
            vy_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
            for (int ky = 0; ky < K_HEIGHT; ky++) begin
                for (int kx = 0; kx < K_WIDTH; kx++) begin
                    win_q[ky][kx] <= '0;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        vx_q    <= '0;
                        vy_q    <= '0;
                    end
                end
                ST_RUN: begin
                    if (adv) begin
                        win_q <= win_d;
                        if (vx_q == X_LAST) begin
                            vx_q <= '0;
                            vy_q <= vy_q + 1'b1;
                        end else begin
                            vx_q <= vx_q + 1'b1;
                        end
                        if (last_pos) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_valid_q && w_ready) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (load) begin
                w_valid_q <= 1'b1;
                w_data_q  <= w_data_d;
            end else if (w_ready) begin
                w_valid_q <= 1'b0;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign w_valid = {IF_PORT{w_valid_q}};
    assign w_data  = w_data_q;

endmodule
